// File: rtl/baccarat_pkg.sv
// Shared types, default rule thresholds and card-code helpers for the Baccarat control stage.
package baccarat_pkg;

    localparam logic [3:0] NATURAL_MIN_DEF = 4'd8;
    localparam logic [3:0] DRAW_MAX_DEF    = 4'd5;

    localparam logic [3:0] CARD_TEN   = 4'd10;
    localparam logic [3:0] CARD_JACK  = 4'd11;
    localparam logic [3:0] CARD_QUEEN = 4'd12;
    localparam logic [3:0] CARD_KING  = 4'd13;

    typedef enum logic [3:0] {
        ST_DEAL_P1,
        ST_DEAL_D1,
        ST_DEAL_P2,
        ST_DEAL_D2,
        ST_EVAL,
        ST_DEAL_P3,
        ST_EVAL_D3,
        ST_DEAL_D3,
        ST_DONE
    } state_t;

    // Face cards and tens count zero; any code from ten upward is treated as a ten.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        return (code >= CARD_TEN) ? 4'd0 : code;
    endfunction

endpackage

// File: rtl/baccarat_fsm_if.sv
// Score inputs, card load strobes and result lights between the control stage and the datapath.
interface baccarat_fsm_if;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;
    logic       game_over;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, game_over
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, game_over
    );
endinterface

// File: rtl/baccarat_fsm_banker_draw_rule.sv
// Punto Banco banker third-card table: given the banker's two-card score and the
// value of the player's third card, decide whether the banker draws.
module banker_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] v,
    output logic       draw
);
    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end
endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat deal sequencer: one state per slow_clock edge, one-hot card load strobes,
// third-card rules and win/tie lights.
module baccarat_fsm
    import baccarat_pkg::*;
#(
    parameter logic [3:0] NATURAL_MIN = NATURAL_MIN_DEF,
    parameter logic [3:0] DRAW_MAX    = DRAW_MAX_DEF
) (
    input  logic           slow_clock,
    input  logic           reset,
    baccarat_fsm_if.master bus
);
    localparam logic [3:0] DEAL_P1 = 4'(ST_DEAL_P1);
    localparam logic [3:0] DEAL_D1 = 4'(ST_DEAL_D1);
    localparam logic [3:0] DEAL_P2 = 4'(ST_DEAL_P2);
    localparam logic [3:0] DEAL_D2 = 4'(ST_DEAL_D2);
    localparam logic [3:0] EVAL    = 4'(ST_EVAL);
    localparam logic [3:0] DEAL_P3 = 4'(ST_DEAL_P3);
    localparam logic [3:0] EVAL_D3 = 4'(ST_EVAL_D3);
    localparam logic [3:0] DEAL_D3 = 4'(ST_DEAL_D3);
    localparam logic [3:0] DONE    = 4'(ST_DONE);

    logic [3:0] state;
    logic [3:0] state_next;
    logic       banker_draws;
    logic       natural;
    logic       done;

    banker_draw_rule u_banker_rule (
        .dscore (bus.dscore),
        .v      (card_value(bus.pcard3)),
        .draw   (banker_draws)
    );

    assign natural = (bus.pscore >= NATURAL_MIN) || (bus.dscore >= NATURAL_MIN);

    always_comb begin
        state_next = state;
        case (state)
            DEAL_P1: state_next = DEAL_D1;
            DEAL_D1: state_next = DEAL_P2;
            DEAL_P2: state_next = DEAL_D2;
            DEAL_D2: state_next = EVAL;
            EVAL: begin
                if (natural)
                    state_next = DONE;
                else if (bus.pscore <= DRAW_MAX)
                    state_next = DEAL_P3;
                else if (bus.dscore <= 4'd5)
                    state_next = DEAL_D3;
                else
                    state_next = DONE;
            end
            DEAL_P3: state_next = EVAL_D3;
            EVAL_D3: state_next = banker_draws ? DEAL_D3 : DONE;
            DEAL_D3: state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = DEAL_P1;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (reset)
            state <= DEAL_P1;
        else
            state <= state_next;
    end

    // Moore outputs, forced low for as long as reset is held.
    assign done = (state == DONE) && !reset;

    assign bus.load_pcard1 = (state == DEAL_P1) && !reset;
    assign bus.load_dcard1 = (state == DEAL_D1) && !reset;
    assign bus.load_pcard2 = (state == DEAL_P2) && !reset;
    assign bus.load_dcard2 = (state == DEAL_D2) && !reset;
    assign bus.load_pcard3 = (state == DEAL_P3) && !reset;
    assign bus.load_dcard3 = (state == DEAL_D3) && !reset;

    // Lights follow the live scores so a final banker card is reflected immediately.
    assign bus.game_over        = done;
    assign bus.player_win_light = done && (bus.pscore >= bus.dscore);
    assign bus.dealer_win_light = done && (bus.dscore >= bus.pscore);
endmodule

// File: doc/baccarat_fsm.md
Name: baccarat_fsm

Overview:
- Control stage for the Baccarat datapath.
- Sequences the deal by pulsing one-hot load strobes that drive the datapath's six card registers.
- Reads back the player score, the dealer score and the player's third card, and applies the Punto Banco third-card rules.
- Drives the win/tie lights. Advances one state per slow_clock edge (one step per key press).

Parameters:
- NATURAL_MIN, 8, lowest two-card score treated as a natural; a natural on either hand ends the deal after four cards.
- DRAW_MAX, 5, highest two-card player score on which the player draws a third card.

Ports:
- slow_clock  input  1  step clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; sampled on the slow_clock rising edge
- pscore  input  4  player hand total mod 10 (0-9), combinational from the datapath card registers
- dscore  input  4  dealer hand total mod 10 (0-9)
- pcard3  input  4  player third card raw code (0 = none, 1-13 = A..K)
- load_pcard1, load_pcard2, load_pcard3  output  1 each  player card register load strobes
- load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card register load strobes
- player_win_light  output  1  player wins (both lights = tie)
- dealer_win_light  output  1  dealer wins
- game_over  output  1  deal complete; FSM parked

Behaviour:
- Interface (already decided): one clock, slow_clock; reset is synchronous and active-high, on port reset.
- States: DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, DEAL_P3, EVAL_D3, DEAL_D3, DONE.
- Moore outputs. Exactly one load strobe is high, and only in the matching DEAL_* state. All strobes are low in EVAL, EVAL_D3 and DONE.
- The card loads on the same edge that leaves its DEAL_* state.
- Reset:
  - Next state is DEAL_P1; all load strobes, lights and game_over read 0 while reset is high.
  - Reset overrides every transition, including mid-deal and in DONE.
  - Datapath registers clear on the same edge; top level handles polarity.
- Fixed sequence: DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> EVAL. Scores are valid in EVAL (one edge after the last load).
- EVAL transitions:
  - pscore >= NATURAL_MIN or dscore >= NATURAL_MIN -> DONE.
  - Else pscore <= DRAW_MAX -> DEAL_P3.
  - Else (player stands on 6-7): dscore <= 5 -> DEAL_D3, otherwise DONE.
- DEAL_P3 -> EVAL_D3 (pcard3 now valid).
- EVAL_D3, banker rule:
  - Card value v = 0 if pcard3 >= 10, else pcard3.
  - Banker draws (-> DEAL_D3) when:
    - dscore 0-2: always.
    - dscore 3: v != 8.
    - dscore 4: v in 2-7.
    - dscore 5: v in 4-7.
    - dscore 6: v in 6-7.
  - dscore 7 (or higher): stands -> DONE.
  - pcard3 = 0 in EVAL_D3 is illegal; treat as v = 0.
- DEAL_D3 -> DONE.
- DONE:
  - Self-loop until reset; game_over = 1.
  - Lights are decoded combinationally from pscore and dscore in DONE, so they are correct after a DEAL_D3 load.
  - pscore > dscore: player light only. dscore > pscore: dealer light only. Equal: both.
  - Lights are 0 in every other state.
- Input scores 10-15 are out of range. Behaviour is defined by the unsigned compares above; no assertion in RTL.
- Comparisons are 4-bit unsigned. No arithmetic beyond compares.

Decomposition:
- Package baccarat_pkg holds:
  - state_t enum.
  - NATURAL_MIN and DRAW_MAX defaults.
  - card_value function (4-bit code -> 0-9).
  - Constants for card codes 10/J/Q/K.
- One combinational sub-module, banker_draw_rule (dscore, v -> draw). It keeps the rule table separately testable and is shared with any future scoring checker.

Test Plan:
- Reset, then 4 clocks with pscore=3 dscore=8 held before EVAL: strobes go P1, D1, P2, D2 one per clock. EVAL -> DONE. Dealer light only, game_over=1, no third-card strobes.
- pscore=9 dscore=9 at EVAL: DONE with both lights (tie) after exactly 5 edges from reset release.
- pscore=6 dscore=4: player stands. load_dcard3 pulses once. Set dscore=7 after it: DONE, dealer light only.
- pscore=2 dscore=5 pcard3=12 (v=0): load_pcard3 pulses, EVAL_D3 -> DONE with no load_dcard3. Then pscore=2 dscore=5 pcard3=4: load_dcard3 pulses.
- Sweep banker_draw_rule over dscore 0-7 x pcard3 1-13 against the rule table. Check dscore=3/v=8 stands, dscore=6/v=7 draws, dscore=7 always stands.
- Assert reset in DEAL_P3 and again in DONE: next edge is DEAL_P1; all strobes, lights and game_over are 0 during reset; the sequence restarts cleanly.
